// File: rtl/alu_4bit.sv
// -----------------------------------------------------------------------------
// alu_4bit -- single-stage registered ALU
//
// Purpose:
//   Combinational datapath (add, sub, and, or, xor, not, shl, shr) feeding one
//   output register stage. There is no internal state machine; the only state
//   is the output register itself.
//
// Build option:
//   ALU_FLAGS_EN -- when defined, adds registered CARRY and OVF outputs.
//                   When undefined, those ports and their logic are absent.
//
// Ports:
//   CLK        in   1      rising-edge clock
//   RST_N      in   1      asynchronous active-low reset
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B (unused for NOT/SHL/SHR)
//   SEL        in   3      operation select
//   IN_VALID   in   1      A/B/SEL valid this cycle
//   OUT        out  WIDTH  registered result
//   ZERO       out  1      registered, high when OUT == 0
//   OUT_VALID  out  1      registered, OUT/ZERO were updated by the last edge
//   CARRY      out  1      registered carry/borrow/shifted-out bit (flags only)
//   OVF        out  1      registered signed overflow (flags only)
//
// Handshake: IN_VALID is sampled on every rising CLK. There is no ready; the
//   ALU accepts one operation per cycle and a result not consumed is simply
//   overwritten by the next valid operation. OUT_VALID is high for exactly the
//   cycle following each accepted operation; with IN_VALID low OUT, ZERO and
//   the flags hold and OUT_VALID drops.
// -----------------------------------------------------------------------------
module alu_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       SEL,
  input  logic             IN_VALID,
  output logic [WIDTH-1:0] OUT,
  output logic             ZERO,
`ifdef ALU_FLAGS_EN
  output logic             CARRY,
  output logic             OVF,
`endif
  output logic             OUT_VALID
);

  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_SUB = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;
  localparam logic [2:0] SEL_XOR = 3'b100;
  localparam logic [2:0] SEL_NOT = 3'b101;
  localparam logic [2:0] SEL_SHL = 3'b110;
  localparam logic [2:0] SEL_SHR = 3'b111;

  // One extra bit on add/sub exposes carry-out / borrow directly.
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] out_d, out_q;
  logic             zero_d, zero_q;
  logic             valid_d, valid_q;

  assign sum_ext  = {1'b0, A} + {1'b0, B};
  assign diff_ext = {1'b0, A} - {1'b0, B};

  always_comb begin
    result = '0;
    unique case (SEL)
      SEL_ADD: result = sum_ext[MSB:0];
      SEL_SUB: result = diff_ext[MSB:0];
      SEL_AND: result = A & B;
      SEL_OR:  result = A | B;
      SEL_XOR: result = A ^ B;
      SEL_NOT: result = ~A;
      SEL_SHL: result = {A[MSB-1:0], 1'b0};
      SEL_SHR: result = {1'b0, A[MSB:1]};
      default: result = '0;
    endcase
  end

  // ZERO is derived from the same result that is loaded into OUT, so the two
  // registers always describe the same operation.
  always_comb begin
    out_d   = out_q;
    zero_d  = zero_q;
    valid_d = 1'b0;
    if (IN_VALID) begin
      out_d   = result;
      zero_d  = (result == '0);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_q   <= '0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign OUT       = out_q;
  assign ZERO      = zero_q;
  assign OUT_VALID = valid_q;

`ifdef ALU_FLAGS_EN
  logic carry_res, ovf_res;
  logic carry_d, carry_q;
  logic ovf_d, ovf_q;

  // Signed overflow: ADD overflows when operands share a sign the result lacks;
  // SUB overflows when operands differ in sign and the result's sign is not A's.
  always_comb begin
    carry_res = 1'b0;
    ovf_res   = 1'b0;
    unique case (SEL)
      SEL_ADD: begin
        carry_res = sum_ext[WIDTH];
        ovf_res   = (A[MSB] == B[MSB]) && (sum_ext[MSB] != A[MSB]);
      end
      SEL_SUB: begin
        carry_res = diff_ext[WIDTH];  // borrow: A < B unsigned
        ovf_res   = (A[MSB] != B[MSB]) && (diff_ext[MSB] != A[MSB]);
      end
      SEL_SHL: carry_res = A[MSB];
      SEL_SHR: carry_res = A[0];
      default: begin
        carry_res = 1'b0;
        ovf_res   = 1'b0;
      end
    endcase
  end

  always_comb begin
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (IN_VALID) begin
      carry_d = carry_res;
      ovf_d   = ovf_res;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign CARRY = carry_q;
  assign OVF   = ovf_q;
`endif

endmodule

// File: tb/tb_alu_4bit.sv
// -----------------------------------------------------------------------------
// tb_alu_4bit -- directed self-checking bench for alu_4bit (WIDTH=4).
// Inputs change on the falling edge; outputs are sampled 1 time unit after the
// rising edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_4bit;

  localparam int WIDTH = 4;

  logic             CLK;
  logic             RST_N;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       SEL;
  logic             IN_VALID;
  logic [WIDTH-1:0] OUT;
  logic             ZERO;
  logic             OUT_VALID;
`ifdef ALU_FLAGS_EN
  logic             CARRY;
  logic             OVF;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];

  // ---------------------------------------------------------------- clock/reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  alu_4bit #(.WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .A         (A),
    .B         (B),
    .SEL       (SEL),
    .IN_VALID  (IN_VALID),
    .OUT       (OUT),
    .ZERO      (ZERO),
`ifdef ALU_FLAGS_EN
    .CARRY     (CARRY),
    .OVF       (OVF),
`endif
    .OUT_VALID (OUT_VALID)
  );

  // ---------------------------------------------------------------- checking
  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_out"},   32'(OUT),       32'h0);
    check_val({tag, "_zero"},  32'(ZERO),      32'h1);
    check_val({tag, "_valid"}, 32'(OUT_VALID), 32'h0);
`ifdef ALU_FLAGS_EN
    check_val({tag, "_carry"}, 32'(CARRY),     32'h0);
    check_val({tag, "_ovf"},   32'(OVF),       32'h0);
`endif
  endtask

  // ---------------------------------------------------------------- drivers
  // Present one valid operation, let it be captured, then compare against the
  // queued expected result. IN_VALID stays high so calls run back-to-back.
  task automatic run_op(input string tag, input logic [3:0] a,
                        input logic [3:0] b, input logic [2:0] sel,
                        input logic [3:0] exp_out, input logic exp_zero,
                        input logic exp_c, input logic exp_v);
    logic [WIDTH-1:0] e;
    @(negedge CLK);
    A        = a;
    B        = b;
    SEL      = sel;
    IN_VALID = 1'b1;
    exp_q.push_back(exp_out);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    check_val({tag, "_out"},   32'(OUT),       32'(e));
    check_val({tag, "_zero"},  32'(ZERO),      32'(exp_zero));
    check_val({tag, "_valid"}, 32'(OUT_VALID), 32'h1);
`ifdef ALU_FLAGS_EN
    check_val({tag, "_carry"}, 32'(CARRY),     32'(exp_c));
    check_val({tag, "_ovf"},   32'(OVF),       32'(exp_v));
`else
    if (exp_c === 1'bx || exp_v === 1'bx) $display("note: x flag expectation in %s", tag);
`endif
  endtask

  task automatic idle_cycle(input logic [3:0] a, input logic [3:0] b,
                            input logic [2:0] sel);
    @(negedge CLK);
    A        = a;
    B        = b;
    SEL      = sel;
    IN_VALID = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [3:0] step_exp [8];

  initial begin
    step_exp[0] = 4'b0100; step_exp[1] = 4'b0010;
    step_exp[2] = 4'b0001; step_exp[3] = 4'b0011;
    step_exp[4] = 4'b0010; step_exp[5] = 4'b1100;
    step_exp[6] = 4'b0110; step_exp[7] = 4'b0001;

    RST_N    = 1'b1;
    A        = '0;
    B        = '0;
    SEL      = '0;
    IN_VALID = 1'b0;

    // Asynchronous reset between edges, then held against valid traffic.
    #2 RST_N = 1'b0;
    #1 check_reset_state("rst_async");
    IN_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A   = 4'($urandom_range(1, 15));
      B   = 4'($urandom_range(0, 15));
      SEL = 3'($urandom_range(0, 7));
      @(posedge CLK);
      #1 check_reset_state("rst_hold");
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    RST_N    = 1'b1;

    // SEL stepped through every operation on consecutive cycles.
    // Flags: ADD 3+1 c0 v0; SUB 3-1 c0 v0; logic ops 0; SHL 0011 -> c=A[3]=0;
    // SHR 0011 -> c=A[0]=1.
    for (int s = 0; s < 8; s++) begin
      run_op($sformatf("step%0d", s), 4'b0011, 4'b0001, 3'(s),
             step_exp[s], 1'b0, (s == 7), 1'b0);
    end

    // Arithmetic boundaries.
    run_op("add_wrap",  4'b1111, 4'b0001, 3'b000, 4'b0000, 1'b1, 1'b1, 1'b0);
    run_op("add_ovf",   4'b0111, 4'b0001, 3'b000, 4'b1000, 1'b0, 1'b0, 1'b1);
    run_op("sub_borrow",4'b0001, 4'b0011, 3'b001, 4'b1110, 1'b0, 1'b1, 1'b0);
    run_op("sub_zero",  4'b0101, 4'b0101, 3'b001, 4'b0000, 1'b1, 1'b0, 1'b0);
    run_op("sub_ovf",   4'b1000, 4'b0001, 3'b001, 4'b0111, 1'b0, 1'b0, 1'b1);

    // Shifts / NOT with B randomised, since B must not matter.
    run_op("shl_out", 4'b1000, 4'($urandom_range(0, 15)), 3'b110,
           4'b0000, 1'b1, 1'b1, 1'b0);
    run_op("shr_out", 4'b0001, 4'($urandom_range(0, 15)), 3'b111,
           4'b0000, 1'b1, 1'b1, 1'b0);
    run_op("not_ff",  4'b1111, 4'($urandom_range(0, 15)), 3'b101,
           4'b0000, 1'b1, 1'b0, 1'b0);

    // Hold: valid op with OVF set, then an idle cycle with inputs changed.
    run_op("pre_hold", 4'b0111, 4'b0001, 3'b000, 4'b1000, 1'b0, 1'b0, 1'b1);
    idle_cycle(4'b0101, 4'b0101, 3'b001);
    check_val("hold_out",   32'(OUT),       32'h8);
    check_val("hold_zero",  32'(ZERO),      32'h0);
    check_val("hold_valid", 32'(OUT_VALID), 32'h0);
`ifdef ALU_FLAGS_EN
    check_val("hold_carry", 32'(CARRY),     32'h0);
    check_val("hold_ovf",   32'(OVF),       32'h1);
`endif
    idle_cycle(4'b1111, 4'b0001, 3'b000);
    check_val("hold2_out",  32'(OUT),       32'h8);

    // Reset mid-stream, between edges, discards the in-flight result.
    run_op("pre_rst", 4'b0011, 4'b0100, 3'b000, 4'b0111, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    A   = 4'b1111;
    B   = 4'b0001;
    SEL = 3'b000;           // would set carry if captured
    #2 RST_N = 1'b0;
    #1 check_reset_state("rst_mid");
    @(posedge CLK);
    #1 check_reset_state("rst_mid_hold");
    @(negedge CLK);
    IN_VALID = 1'b0;
    RST_N    = 1'b1;
    @(posedge CLK);
    #1 check_reset_state("rst_release_idle");
    run_op("post_rst", 4'b0110, 4'b0010, 3'b001, 4'b0100, 1'b0, 1'b0, 1'b0);

    @(negedge CLK);
    IN_VALID = 1'b0;
    @(posedge CLK);
    #1 check_val("final_valid", 32'(OUT_VALID), 32'h0);
    check_val("exp_q_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
